// File: rtl/rpsc_supply_seq.sv
// RPSC cathode-anode supply sequencer.
// Checks the permissive, waits through a settle time and a CA delay, then
// runs and supervises the supply, tripping on status or run-time faults.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   status_i     per-channel fault inputs, 1 = fault
//   status_mask  per-channel ignore mask, 1 = channel ignored
//   g1_not_ok    grid-1 supply not OK
//   fan_ok       fan running
//   ca_ps_act    CA supply request
//   i_ca_high    run-time CA current-high monitor
//   u_ca_low     run-time CA voltage-low monitor
//   fault_ack    operator acknowledge of a latched trip
//   not_alarm    1 = no unmasked status fault present
//   ca_on_perm   1 = permissive true
//   ca_delay     1 = sequencer in DELAY
//   not_ca_ok    0 only while in RUN
//   trip         1 while in TRIP
//   trip_cause   0 none, 1 status, 2 I high, 3 U low
//   first_fault  unmasked status vector captured at trip entry
//   state        IDLE=0 SETTLE=1 DELAY=2 RUN=3 TRIP=4

module rpsc_supply_seq #(
    parameter int N_STATUS   = 7,
    parameter int SETTLE_CYC = 256,
    parameter int DELAY_CYC  = 3840
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_STATUS-1:0] status_i,
    input  logic [N_STATUS-1:0] status_mask,
    input  logic                g1_not_ok,
    input  logic                fan_ok,
    input  logic                ca_ps_act,
    input  logic                i_ca_high,
    input  logic                u_ca_low,
    input  logic                fault_ack,
    output logic                not_alarm,
    output logic                ca_on_perm,
    output logic                ca_delay,
    output logic                not_ca_ok,
    output logic                trip,
    output logic [1:0]          trip_cause,
    output logic [N_STATUS-1:0] first_fault,
    output logic [2:0]          state
);

    // ------------------------------------------------------------------
    // Local parameters and types
    // ------------------------------------------------------------------
    localparam int MAX_CYC = (SETTLE_CYC > DELAY_CYC) ? SETTLE_CYC : DELAY_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_DELAY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_TRIP   = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_STATUS = 2'd1;
    localparam logic [1:0] CAUSE_IHIGH  = 2'd2;
    localparam logic [1:0] CAUSE_ULOW   = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_not_alarm;
    logic                r_ca_on_perm;
    logic                r_ca_delay;
    logic                r_not_ca_ok;
    logic                r_trip;
    logic [1:0]          r_trip_cause;
    logic [N_STATUS-1:0] r_first_fault;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_STATUS-1:0] w_unmasked;
    logic                w_fault;
    logic                w_permit;
    logic                w_go;
    state_t              w_next;
    logic [1:0]          w_cause;
    logic [CW-1:0]       w_cnt_next;
    logic                w_not_alarm;
    logic                w_ca_on_perm;
    logic                w_ca_delay;
    logic                w_not_ca_ok;
    logic                w_trip;
    logic [1:0]          w_trip_cause;
    logic [N_STATUS-1:0] w_first_fault;

    assign w_unmasked = status_i & ~status_mask;
    assign w_fault    = |w_unmasked;
    assign w_permit   = ~w_fault & ~g1_not_ok & fan_ok;
    assign w_go       = w_permit & ca_ps_act;

    // ------------------------------------------------------------------
    // State register (with shared counter and trip capture)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_not_alarm   <= 1'b1;
            r_ca_on_perm  <= 1'b0;
            r_ca_delay    <= 1'b0;
            r_not_ca_ok   <= 1'b1;
            r_trip        <= 1'b0;
            r_trip_cause  <= CAUSE_NONE;
            r_first_fault <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= w_cnt_next;
            r_not_alarm   <= w_not_alarm;
            r_ca_on_perm  <= w_ca_on_perm;
            r_ca_delay    <= w_ca_delay;
            r_not_ca_ok   <= w_not_ca_ok;
            r_trip        <= w_trip;
            r_trip_cause  <= w_trip_cause;
            r_first_fault <= w_first_fault;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // Priority: status fault > I high > U low > go drop > count expiry.
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_cause = CAUSE_NONE;
        unique case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_fault) begin
                    w_next  = ST_TRIP;
                    w_cause = CAUSE_STATUS;
                end else if (!w_go) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (w_fault) begin
                    w_next  = ST_TRIP;
                    w_cause = CAUSE_STATUS;
                end else if (!w_go) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == DELAY_LAST) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Current/voltage monitors only matter once the supply runs.
                if (w_fault) begin
                    w_next  = ST_TRIP;
                    w_cause = CAUSE_STATUS;
                end else if (i_ca_high) begin
                    w_next  = ST_TRIP;
                    w_cause = CAUSE_IHIGH;
                end else if (u_ca_low) begin
                    w_next  = ST_TRIP;
                    w_cause = CAUSE_ULOW;
                end else if (!w_go) begin
                    w_next = ST_IDLE;
                end
            end
            ST_TRIP: begin
                // Ack is honoured only once the status fault has gone.
                if (fault_ack && !w_fault) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter: restarts on every state change, counts in timed states
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = '0;
        if (w_next == r_state &&
            (r_state == ST_SETTLE || r_state == ST_DELAY)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (values registered on the next edge)
    // ------------------------------------------------------------------
    always_comb begin
        w_not_alarm   = ~w_fault;
        w_ca_on_perm  = w_permit;
        w_ca_delay    = (r_state == ST_DELAY);
        w_not_ca_ok   = (r_state != ST_RUN);
        w_trip        = (r_state == ST_TRIP);
        w_trip_cause  = r_trip_cause;
        w_first_fault = r_first_fault;
        if (r_state != ST_TRIP && w_next == ST_TRIP) begin
            // Freeze the fault picture seen at the moment of the trip.
            w_trip_cause  = w_cause;
            w_first_fault = w_unmasked;
        end else if (r_state == ST_TRIP && w_next == ST_IDLE) begin
            w_trip_cause  = CAUSE_NONE;
            w_first_fault = '0;
        end
    end

    assign not_alarm   = r_not_alarm;
    assign ca_on_perm  = r_ca_on_perm;
    assign ca_delay    = r_ca_delay;
    assign not_ca_ok   = r_not_ca_ok;
    assign trip        = r_trip;
    assign trip_cause  = r_trip_cause;
    assign first_fault = r_first_fault;
    assign state       = r_state;

endmodule

// File: doc/rpsc_supply_seq.md
RPSC_SUPPLY_SEQ -- requirements
Module: rpsc_supply_seq

Interface
REQ-001 The block SHALL have parameter N_STATUS, default 7, meaning the number of status fault inputs.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 256, meaning the permissive settle time in clk cycles (4 s at 64 Hz).
REQ-003 The block SHALL have parameter DELAY_CYC, default 3840, meaning the post-settle CA delay in clk cycles (60 s at 64 Hz); SETTLE_CYC and DELAY_CYC SHALL both be >= 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 status_i  in  N_STATUS  per-channel fault, 1 = fault (card pos, air/water, DC PS, U low, I high).
REQ-008 status_mask  in  N_STATUS  1 = channel ignored.
REQ-009 g1_not_ok  in  1  grid-1 supply not OK.
REQ-010 fan_ok  in  1  fan running.
REQ-011 ca_ps_act  in  1  CA supply request.
REQ-012 i_ca_high, u_ca_low  in  1 each  run-time CA current-high / voltage-low monitors.
REQ-013 fault_ack  in  1  operator acknowledge of a latched trip.
REQ-014 not_alarm  out  1  1 = no unmasked status fault present.
REQ-015 ca_on_perm  out  1  1 = permissive true.
REQ-016 ca_delay  out  1  1 = in DELAY state.
REQ-017 not_ca_ok  out  1  0 only in RUN.
REQ-018 trip  out  1  1 in TRIP.
REQ-019 trip_cause  out  2  0 none, 1 status, 2 I high, 3 U low.
REQ-020 first_fault  out  N_STATUS  unmasked status vector captured at trip entry.
REQ-021 state  out  3  IDLE=0, SETTLE=1, DELAY=2, RUN=3, TRIP=4.

Function
REQ-022 fault = OR(status_i & ~status_mask); permit = ~fault & ~g1_not_ok & fan_ok; go = permit & ca_ps_act.
REQ-023 All outputs SHALL be registered, updating one cycle after the sampled input.
REQ-024 One counter of width $clog2(max(SETTLE_CYC,DELAY_CYC)+1) SHALL be cleared on every state change.
REQ-025 IDLE: go -> SETTLE; otherwise stay.
REQ-026 SETTLE: fault -> TRIP; else ~go -> IDLE; else counter == SETTLE_CYC-1 -> DELAY; else counter increments.
REQ-027 DELAY: same rules as SETTLE with DELAY_CYC-1 -> RUN.
REQ-028 RUN: fault -> TRIP (cause 1); else i_ca_high -> TRIP (cause 2); else u_ca_low -> TRIP (cause 3); else ~go -> IDLE.
REQ-029 Priority on simultaneous events: status fault > I high > U low > go drop > count expiry.
REQ-030 i_ca_high and u_ca_low SHALL be ignored outside RUN.
REQ-031 On TRIP entry, first_fault SHALL capture status_i & ~status_mask and trip_cause SHALL be set; neither SHALL change while in TRIP.
REQ-032 TRIP -> IDLE only when fault_ack=1 and fault=0 in the same cycle; on exit, first_fault and trip_cause SHALL clear to 0.
REQ-033 fault_ack outside TRIP, or with fault still present, SHALL have no effect.
REQ-034 Latency: with go held from cycle 0, the block enters RUN after 1 + SETTLE_CYC + DELAY_CYC cycles.

Reset
REQ-035 While reset=0: state=IDLE, counter=0, not_alarm=1, ca_on_perm=0, ca_delay=0, not_ca_ok=1, trip=0, trip_cause=0, first_fault=0.
REQ-036 Reset asserted mid-sequence or in TRIP SHALL abort immediately to the REQ-035 values; no trip memory survives reset.

Verification (SETTLE_CYC=4, DELAY_CYC=8, N_STATUS=7)
REQ-037 Hold go from cycle 0 -> state 1 at cycle 1, 2 at cycle 5, 3 at cycle 13; not_ca_ok falls at cycle 14.
REQ-038 Drop ca_ps_act during DELAY -> IDLE, trip=0, counter restarts from 0 on the next go.
REQ-039 status_i=7'b0000100 in RUN -> TRIP, trip_cause=1, first_fault=7'b0000100; same bit with status_mask bit 2 set -> stays in RUN.
REQ-040 i_ca_high=1 and u_ca_low=1 together in RUN -> trip_cause=2; the same pulse in DELAY -> ignored.
REQ-041 fault_ack with fault present -> remains in TRIP; ack after fault clears -> IDLE, first_fault=0.
REQ-042 reset pulse (0) in SETTLE and in TRIP -> all outputs at REQ-035 values within the same cycle.
